// File: rtl/ila_dma_framer_pkg.sv
// Shared types for the ILA DMA framer: FSM state encoding and default widths.
package ila_dma_framer_pkg;

    // Two-bit state encoding used by the framer FSM.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2,
        ST_DRAIN   = 2'd3
    } framer_state_e;

    // Default stream word width and payload length field width.
    localparam int FRAMER_DATA_W = 32;
    localparam int FRAMER_LEN_W  = 16;

endpackage

// File: rtl/ila_stream_reg.sv
// Single-entry valid/ready output holding register for ILA stream stages.
// The owner must only pulse load_i while free_o is high, so a held word
// never changes before the downstream side has taken it.
module ila_stream_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              tready_i,
    output logic              free_o,
    output logic [DATA_W-1:0] tdata_o,
    output logic              tvalid_o,
    output logic              tlast_o
);

    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;

    assign free_o   = ~tvalid_q | tready_i;
    assign tdata_o  = tdata_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;

    // Next word: clear wins, then a new load, otherwise drop the word once accepted.
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (clr_i) begin
            tdata_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end else if (load_i) begin
            tdata_d  = data_i;
            tvalid_d = 1'b1;
            tlast_d  = last_i;
        end else if (tvalid_q && tready_i) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    // Holding register, frozen while the clock enable is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (cke_i) begin
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

endmodule

// File: rtl/ila_dma_framer.sv
// Frames raw ILA sample words for the DMA engine: header {tag, length},
// exactly length payload words, then an XOR checksum trailer with tlast.
module ila_dma_framer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    cke_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [LEN_W-1:0]        frame_len_i,
    input  logic [DATA_W-LEN_W-1:0] tag_i,
    input  logic [DATA_W-1:0]       s_tdata_i,
    input  logic                    s_tvalid_i,
    output logic                    s_tready_o,
    output logic [DATA_W-1:0]       m_tdata_o,
    output logic                    m_tvalid_o,
    output logic                    m_tlast_o,
    input  logic                    m_tready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [LEN_W-1:0]        words_o
);
    import ila_dma_framer_pkg::*;

    framer_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              done_q, done_d;

    logic              out_free;
    logic              out_load;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              in_hs;
    logic [LEN_W-1:0]  cnt_inc;

    // The header tag needs no separate latch: the header word itself is
    // captured in the output register on the same edge start_i is accepted.
    assign cnt_inc    = cnt_q + LEN_W'(1);
    assign in_hs      = s_tready_o & s_tvalid_i;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign words_o    = cnt_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
        end else if (cke_i) begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the soft clear abandons any frame in flight.
    always_comb begin
        state_d = state_q;
        if (rst_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = (frame_len_i == '0) ? ST_TRAILER : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (in_hs && (cnt_inc == len_q)) begin
                        state_d = ST_TRAILER;
                    end
                end
                ST_TRAILER: begin
                    if (out_free) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (m_tvalid_o && m_tready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode: what to load into the output register and input readiness.
    always_comb begin
        s_tready_o = 1'b0;
        out_load   = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    out_load = 1'b1;
                    out_data = {tag_i, frame_len_i};
                end
            end
            ST_PAYLOAD: begin
                s_tready_o = out_free;
                if (s_tvalid_i && out_free) begin
                    out_load = 1'b1;
                    out_data = s_tdata_i;
                end
            end
            ST_TRAILER: begin
                if (out_free) begin
                    out_load = 1'b1;
                    out_data = csum_q;
                    out_last = 1'b1;
                end
            end
            default: begin
                out_load = 1'b0;
            end
        endcase
    end

    // Datapath next values: length latch, payload counter, checksum, done pulse.
    always_comb begin
        len_d  = len_q;
        cnt_d  = cnt_q;
        csum_d = csum_q;
        done_d = 1'b0;
        if (rst_i) begin
            cnt_d  = '0;
            csum_d = '0;
        end else begin
            if ((state_q == ST_IDLE) && start_i) begin
                len_d  = frame_len_i;
                cnt_d  = '0;
                csum_d = '0;
            end
            if (in_hs) begin
                cnt_d  = cnt_inc;
                csum_d = csum_q ^ s_tdata_i;
            end
            if ((state_q == ST_DRAIN) && m_tvalid_o && m_tready_i) begin
                done_d = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            len_q  <= '0;
            cnt_q  <= '0;
            csum_q <= '0;
            done_q <= 1'b0;
        end else if (cke_i) begin
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            csum_q <= csum_d;
            done_q <= done_d;
        end
    end

    ila_stream_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .clr_i    (rst_i),
        .load_i   (out_load),
        .data_i   (out_data),
        .last_i   (out_last),
        .tready_i (m_tready_i),
        .free_o   (out_free),
        .tdata_o  (m_tdata_o),
        .tvalid_o (m_tvalid_o),
        .tlast_o  (m_tlast_o)
    );

endmodule

// File: tb/tb_ila_dma_framer.sv
// Scoreboard bench for ila_dma_framer: stimulus pushes expected beats,
// a monitor pops and compares every accepted output beat.
module tb_ila_dma_framer;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int TAG_W  = DATA_W - LEN_W;

    logic              clk = 1'b0;
    logic              arstN;
    logic              cke;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  frameLen;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] sTdata;
    logic              sTvalid;
    logic              sTready;
    logic [DATA_W-1:0] mTdata;
    logic              mTvalid;
    logic              mTlast;
    logic              mTready;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  words;

    logic              readyReg  = 1'b1;
    logic              forceLow  = 1'b0;
    bit                patternOn = 1'b0;
    logic [15:0]       pattern   = 16'b1011_0011_1000_1101;

    int total     = 0;
    int bad       = 0;
    int doneCount = 0;
    int doneBase  = 0;
    bit sawTready = 1'b0;

    logic [DATA_W:0]   expQ[$];
    logic [DATA_W-1:0] payload[$];
    logic [DATA_W:0]   expBeat;
    logic [DATA_W-1:0] prevData = '0;
    bit                prevStall = 1'b0;
    bit                prevRst   = 1'b0;

    assign mTready = readyReg & ~forceLow;

    always #5 clk = ~clk;

    ila_dma_framer #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (arstN),
        .cke_i       (cke),
        .rst_i       (rst),
        .start_i     (start),
        .frame_len_i (frameLen),
        .tag_i       (tag),
        .s_tdata_i   (sTdata),
        .s_tvalid_i  (sTvalid),
        .s_tready_o  (sTready),
        .m_tdata_o   (mTdata),
        .m_tvalid_o  (mTvalid),
        .m_tlast_o   (mTlast),
        .m_tready_i  (mTready),
        .busy_o      (busy),
        .done_o      (done),
        .words_o     (words)
    );

    function automatic void compare(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endfunction

    // Downstream ready: constantly high, or a rotating pseudo-random pattern.
    always @(negedge clk) begin
        if (patternOn) begin
            readyReg = pattern[0];
            pattern  = {pattern[0], pattern[15:1]};
        end else begin
            readyReg = 1'b1;
        end
    end

    // Monitor: pop and compare every accepted beat, check stalled words stay put.
    always @(negedge clk) begin
        #2;
        if (!arstN) begin
            prevStall = 1'b0;
            prevRst   = 1'b0;
        end else begin
            if (prevStall && !prevRst) begin
                compare("stall_valid", 64'(mTvalid), 64'd1);
                compare("stall_data", 64'(mTdata), 64'(prevData));
            end
            if (sTready) sawTready = 1'b1;
            if (done) doneCount++;
            if (mTvalid && mTready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_beat got=0x%0h expected=none", {mTlast, mTdata});
                end else begin
                    expBeat = expQ.pop_front();
                    compare("beat", 64'({mTlast, mTdata}), 64'(expBeat));
                end
            end
            prevStall = mTvalid && !mTready;
            prevData  = mTdata;
            prevRst   = rst;
        end
    end

    task automatic checkResetOutputs(input string tagName);
        compare({tagName, "_s_tready"}, 64'(sTready), 64'd0);
        compare({tagName, "_m_tdata"}, 64'(mTdata), 64'd0);
        compare({tagName, "_m_tvalid"}, 64'(mTvalid), 64'd0);
        compare({tagName, "_m_tlast"}, 64'(mTlast), 64'd0);
        compare({tagName, "_busy"}, 64'(busy), 64'd0);
        compare({tagName, "_done"}, 64'(done), 64'd0);
        compare({tagName, "_words"}, 64'(words), 64'd0);
    endtask

    // Issue one frame request and feed nFeed payload words; expected beats are queued first.
    task automatic applyStimulus(input logic [LEN_W-1:0] len, input logic [TAG_W-1:0] tagVal,
                                 input int nFeed, input bit midStart);
        logic [DATA_W-1:0] csum;
        bit accepted;
        int guard;
        csum = '0;
        doneBase = doneCount;
        expQ.push_back({1'b0, tagVal, len});
        for (int i = 0; i < nFeed; i++) begin
            expQ.push_back({1'b0, payload[i]});
        end
        for (int i = 0; i < int'(len); i++) begin
            csum = csum ^ payload[i];
        end
        if (nFeed == int'(len)) expQ.push_back({1'b1, csum});
        frameLen = len;
        tag      = tagVal;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        frameLen = '0;
        tag      = '0;
        #1;
        compare("header_valid", 64'(mTvalid), 64'd1);
        compare("busy_in_frame", 64'(busy), 64'd1);
        for (int i = 0; i < nFeed; i++) begin
            sTdata   = payload[i];
            sTvalid  = 1'b1;
            accepted = 1'b0;
            guard    = 0;
            if (midStart && i == 1) begin
                start    = 1'b1;
                frameLen = 16'd7;
            end
            while (!accepted && guard < 200) begin
                #1;
                accepted = sTready;
                @(negedge clk);
                start    = 1'b0;
                frameLen = '0;
                guard++;
            end
            if (!accepted) begin
                total++;
                bad++;
                $display("[TB] FAIL feed_timeout word=%0d got=stalled expected=accepted", i);
            end
        end
        sTvalid = 1'b0;
    endtask

    // Wait (bounded) for the done pulse, then check counts and final status.
    task automatic checkOutput(input logic [LEN_W-1:0] len);
        int guard;
        guard = 0;
        while (doneCount == doneBase && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        compare("done_seen", 64'(doneCount > doneBase), 64'd1);
        repeat (3) @(negedge clk);
        #3;
        compare("done_pulses", 64'(doneCount - doneBase), 64'd1);
        compare("all_beats_out", 64'(expQ.size()), 64'd0);
        compare("words_after_done", 64'(words), 64'(len));
        compare("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        arstN    = 1'b0;
        cke      = 1'b1;
        rst      = 1'b0;
        start    = 1'b0;
        frameLen = '0;
        tag      = '0;
        sTdata   = '0;
        sTvalid  = 1'b0;
        #2;
        checkResetOutputs("reset");
        @(negedge clk);
        arstN = 1'b1;
        @(negedge clk);

        $display("[TB] basic frame");
        payload = '{32'h11, 32'h22, 32'h44};
        applyStimulus(16'd3, 16'hA5A5, 3, 1'b0);
        checkOutput(16'd3);

        $display("[TB] empty frame");
        sawTready = 1'b0;
        payload   = '{};
        applyStimulus(16'd0, 16'h0001, 0, 1'b0);
        checkOutput(16'd0);
        compare("empty_no_tready", 64'(sawTready), 64'd0);

        $display("[TB] backpressure frame");
        patternOn = 1'b1;
        payload   = '{32'h0102_0304, 32'hF0F0_0F0F, 32'h1234_5678, 32'h8000_0001,
                      32'hCAFE_BABE, 32'h0000_FFFF, 32'h5555_AAAA, 32'h7E57_0008};
        applyStimulus(16'd8, 16'h00B8, 8, 1'b0);
        checkOutput(16'd8);
        patternOn = 1'b0;

        $display("[TB] start during payload");
        payload = '{32'h5, 32'h6, 32'h7};
        applyStimulus(16'd3, 16'h0042, 3, 1'b1);
        checkOutput(16'd3);
        payload = '{32'h99};
        applyStimulus(16'd1, 16'h0043, 1, 1'b0);
        checkOutput(16'd1);

        $display("[TB] soft clear mid-frame");
        payload = '{32'hA0A0_A0A0, 32'h0B0B_0B0B, 32'h3, 32'h4, 32'h5};
        applyStimulus(16'd5, 16'h0055, 2, 1'b0);
        forceLow = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare("rst_m_tvalid", 64'(mTvalid), 64'd0);
        compare("rst_m_tlast", 64'(mTlast), 64'd0);
        compare("rst_busy", 64'(busy), 64'd0);
        compare("rst_words", 64'(words), 64'd0);
        expQ.delete();
        forceLow = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        compare("rst_no_done", 64'(doneCount - doneBase), 64'd0);
        payload = '{32'hDEAD_BEEF};
        applyStimulus(16'd1, 16'h0007, 1, 1'b0);
        checkOutput(16'd1);

        $display("[TB] async reset mid-frame");
        payload = '{32'h1, 32'h2, 32'h3, 32'h4};
        applyStimulus(16'd4, 16'h0003, 2, 1'b0);
        #3;
        arstN = 1'b0;
        #1;
        checkResetOutputs("arst");
        expQ.delete();
        @(negedge clk);
        arstN = 1'b1;
        @(negedge clk);
        payload = '{32'h11, 32'h22, 32'h44};
        applyStimulus(16'd3, 16'hA5A5, 3, 1'b0);
        checkOutput(16'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
